lcd_panel_rx: RTL and testbench

Synthesizable receiver for the 8-bit parallel graphic-LCD bus (KS0108-style page/column protocol) driven by the team's LCD controller. It sits on the panel side of the `LCD_*` pins and decodes write strobes into commands and data. It mirrors the panel's 8×64-byte display RAM and exposes that RAM on a read port, so on-chip checkers and simulation benches can compare rendered frames against expected memory contents.

---
 rtl/lcd_panel_rx.sv | 164 ++++++++++++++++
 tb/tb_lcd_panel_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_panel_rx.sv
// lcd_panel_rx: panel-side receiver for the 8-bit KS0108-style LCD bus.
// Decodes write strobes into commands and data writes, mirrors the
// 8x64-byte display RAM and exposes it on a registered read port.
// Optional feature macro: LCD_RX_BUSY_EN (emulated panel busy window).
module lcd_panel_rx #(
  parameter logic [1:0] CS_MATCH = 2'b10,
  parameter int         BUSY_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LCD_en,
  input  logic        LCD_di,
  input  logic        LCD_rw,
  input  logic        LCD_rst,
  input  logic [1:0]  LCD_cs,
  input  logic [7:0]  LCD_data,
  input  logic [8:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        disp_on,
  output logic [5:0]  start_line,
  output logic [2:0]  page,
  output logic [5:0]  y_addr,
  output logic [15:0] wr_cnt,
  output logic        frame_done,
  output logic        cmd_err,
  output logic        busy
);

`ifdef LCD_RX_BUSY_EN
  localparam bit BUSY_ON = 1'b1;
`else
  localparam bit BUSY_ON = 1'b0;
`endif

  localparam int BW = (BUSY_CYC < 2) ? 1 : $clog2(BUSY_CYC + 1);

  logic          r_en_d;
  logic          r_di_q;
  logic [7:0]    r_data_q;
  logic [7:0]    r_mem [512];
  logic [7:0]    r_rd_data;
  logic          r_disp_on;
  logic [5:0]    r_start_line;
  logic [2:0]    r_page;
  logic [5:0]    r_y_addr;
  logic [15:0]   r_wr_cnt;
  logic          r_frame_done;
  logic          r_cmd_err;
  logic [BW-1:0] r_busy_cnt;

  logic          w_commit;
  logic          w_busy;
  logic          w_accept;
  logic          w_drop;
  logic          w_wr;
  logic          w_cmd;
  logic          w_is_disp;
  logic          w_is_y;
  logic          w_is_page;
  logic          w_is_start;
  logic          w_bad_cmd;
  logic [8:0]    w_wr_addr;

  // A commit is the falling edge of the strobe, seen with this half selected
  // and the panel out of reset; the latched di/data carry the payload.
  assign w_commit  = r_en_d & ~LCD_en & (LCD_cs == CS_MATCH) & LCD_rst;
  assign w_busy    = BUSY_ON & (r_busy_cnt != '0);
  assign w_accept  = w_commit & ~w_busy;
  assign w_drop    = w_commit & w_busy;
  assign w_wr      = w_accept & ~LCD_rw & r_di_q;
  assign w_cmd     = w_accept & ~LCD_rw & ~r_di_q;
  assign w_wr_addr = {r_page, r_y_addr};

  // Command opcode decode from the latched bus byte.
  always_comb begin
    w_is_disp  = (r_data_q[7:1] == 7'b0011111);
    w_is_y     = (r_data_q[7:6] == 2'b01);
    w_is_page  = (r_data_q[7:3] == 5'b10111);
    w_is_start = (r_data_q[7:6] == 2'b11);
    w_bad_cmd  = w_cmd & ~(w_is_disp | w_is_y | w_is_page | w_is_start);
  end

  // Bus sampling: delayed strobe always tracks, payload latched while en high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d   <= 1'b0;
      r_di_q   <= 1'b0;
      r_data_q <= 8'h00;
    end else begin
      r_en_d <= LCD_en;
      if (LCD_en) begin
        r_di_q   <= LCD_di;
        r_data_q <= LCD_data;
      end
    end
  end

  // Panel registers, write counter and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_on    <= 1'b0;
      r_start_line <= 6'd0;
      r_page       <= 3'd0;
      r_y_addr     <= 6'd0;
      r_wr_cnt     <= 16'h0000;
      r_frame_done <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else if (!LCD_rst) begin
      // Panel reset clears addressing/display state but keeps RAM and count.
      r_disp_on    <= 1'b0;
      r_start_line <= 6'd0;
      r_page       <= 3'd0;
      r_y_addr     <= 6'd0;
      r_frame_done <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_frame_done <= w_wr & (w_wr_addr == 9'h1FF);
      r_cmd_err    <= w_bad_cmd | (w_accept & LCD_rw) | w_drop;
      if (w_cmd) begin
        if (w_is_disp)  r_disp_on    <= r_data_q[0];
        if (w_is_y)     r_y_addr     <= r_data_q[5:0];
        if (w_is_page)  r_page       <= r_data_q[2:0];
        if (w_is_start) r_start_line <= r_data_q[5:0];
      end
      if (w_wr) begin
        r_y_addr <= r_y_addr + 6'd1;
        if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  // Busy window counter; stays at zero when the busy feature is compiled out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cnt <= '0;
    end else if (BUSY_ON && w_accept) begin
      r_busy_cnt <= BW'(BUSY_CYC);
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - 1'b1;
    end
  end

  // Display RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_wr_addr] <= r_data_q;
  end

  // Registered read port, read-first against a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= 8'h00;
    else        r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data    = r_rd_data;
  assign disp_on    = r_disp_on;
  assign start_line = r_start_line;
  assign page       = r_page;
  assign y_addr     = r_y_addr;
  assign wr_cnt     = r_wr_cnt;
  assign frame_done = r_frame_done;
  assign cmd_err    = r_cmd_err;
  assign busy       = w_busy;

endmodule

// File: tb/tb_lcd_panel_rx.sv
// tb_lcd_panel_rx: directed and random strobe traffic against a
// transaction-level model of the panel (RAM array plus address state).
module tb_lcd_panel_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        LCD_en, LCD_di, LCD_rw, LCD_rst;
  logic [1:0]  LCD_cs;
  logic [7:0]  LCD_data;
  logic [8:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        disp_on;
  logic [5:0]  start_line;
  logic [2:0]  page;
  logic [5:0]  y_addr;
  logic [15:0] wr_cnt;
  logic        frame_done, cmd_err, busy;

  always #5 clk = ~clk;

  lcd_panel_rx dut (
    .clk(clk), .rst_n(rst_n), .LCD_en(LCD_en), .LCD_di(LCD_di), .LCD_rw(LCD_rw),
    .LCD_rst(LCD_rst), .LCD_cs(LCD_cs), .LCD_data(LCD_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .disp_on(disp_on), .start_line(start_line), .page(page),
    .y_addr(y_addr), .wr_cnt(wr_cnt), .frame_done(frame_done), .cmd_err(cmd_err),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: panel state as plain integers, RAM as a 512-entry array.
  logic [7:0] m_mem [512];
  bit         m_val [512];
  int         m_page, m_y, m_sl, m_disp, m_cnt;
  bit         m_fd, m_err;

  task automatic model_strobe(input bit di, input logic [7:0] d, input logic [1:0] cs, input bit rw);
    int a;
    m_fd  = 0;
    m_err = 0;
    if (cs != 2'b10) return;
    if (rw) begin
      m_err = 1;
      return;
    end
    if (!di) begin
      if (d == 8'h3E || d == 8'h3F)  m_disp = int'(d) - 62;
      else if (d >= 64 && d < 128)   m_y    = int'(d) - 64;
      else if (d >= 184 && d < 192)  m_page = int'(d) - 184;
      else if (d >= 192)             m_sl   = int'(d) - 192;
      else                           m_err  = 1;
    end else begin
      a = m_page * 64 + m_y;
      m_mem[a] = d;
      m_val[a] = 1;
      m_fd = (a == 511);
      m_y = (m_y + 1) % 64;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic check_state(input string where);
    chk({where, ".page"},       32'(page),       32'(m_page));
    chk({where, ".y_addr"},     32'(y_addr),     32'(m_y));
    chk({where, ".disp_on"},    32'(disp_on),    32'(m_disp));
    chk({where, ".start_line"}, 32'(start_line), 32'(m_sl));
    chk({where, ".wr_cnt"},     32'(wr_cnt),     32'(m_cnt));
    chk({where, ".frame_done"}, 32'(frame_done), 32'(m_fd));
    chk({where, ".cmd_err"},    32'(cmd_err),    32'(m_err));
    chk({where, ".busy"},       32'(busy),       32'(0));
  endtask

  // One strobe at minimum spacing: en high one cycle, low one cycle.
  // Entered and left #1 after a rising edge; checks land right after commit.
  task automatic strobe(input bit di, input logic [7:0] d, input logic [1:0] cs, input bit rw);
    LCD_en = 1'b1; LCD_di = di; LCD_data = d; LCD_cs = cs; LCD_rw = rw;
    @(posedge clk); #1;
    LCD_en = 1'b0; LCD_di = 1'($urandom); LCD_data = 8'($urandom);
    @(posedge clk); #1;
    model_strobe(di, d, cs, rw);
    check_state("strobe");
  endtask

  task automatic cmd(input logic [7:0] d);
    strobe(1'b0, d, 2'b10, 1'b0);
  endtask

  task automatic dat(input logic [7:0] d);
    strobe(1'b1, d, 2'b10, 1'b0);
  endtask

  task automatic read_check(input int a);
    rd_addr = 9'(a);
    @(posedge clk); #1;
    if (m_val[a]) chk("rd_data", 32'(rd_data), 32'(m_mem[a]));
  endtask

  // Panel reset with strobe noise on the bus; released with en low.
  task automatic lcd_reset(input int n);
    LCD_rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      LCD_en = 1'($urandom); LCD_cs = 2'b10; LCD_rw = 1'b0;
      LCD_di = 1'($urandom); LCD_data = 8'($urandom);
      @(posedge clk); #1;
    end
    LCD_en = 1'b0;
    @(posedge clk); #1;
    LCD_rst = 1'b1;
    m_page = 0; m_y = 0; m_sl = 0; m_disp = 0; m_fd = 0; m_err = 0;
    check_state("lcd_rst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [1:0] cs;
    bit di, rw;

    m_page = 0; m_y = 0; m_sl = 0; m_disp = 0; m_cnt = 0; m_fd = 0; m_err = 0;
    for (int i = 0; i < 512; i++) m_val[i] = 0;

    rst_n = 1'b0; LCD_en = 1'b0; LCD_di = 1'b0; LCD_rw = 1'b0; LCD_rst = 1'b1;
    LCD_cs = 2'b10; LCD_data = 8'h00; rd_addr = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rd_data", 32'(rd_data), 32'(0));
    check_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("post_reset");

    // Address 0 reads back zero once written.
    cmd(8'hB8); cmd(8'h40); dat(8'h00);
    read_check(0);

    // Page/column commands followed by two data bytes.
    cmd(8'hBB); cmd(8'h45); dat(8'hA5); dat(8'h5A);
    read_check(3 * 64 + 5);
    read_check(3 * 64 + 6);

    // Last column of last page: wrap and single frame_done pulse.
    cmd(8'hBF); cmd(8'h7F); dat(8'h11);
    @(posedge clk); #1;
    chk("frame_done_once", 32'(frame_done), 32'(0));
    read_check(511);

    // Error and select handling.
    cmd(8'h00);
    strobe(1'b1, 8'hEE, 2'b01, 1'b0);
    strobe(1'b1, 8'hDD, 2'b10, 1'b1);
    strobe(1'b0, 8'hB9, 2'b00, 1'b0);
    read_check(7 * 64 + 0);

    // Read-first: overwrite an address while reading it in the same cycle.
    cmd(8'hBA); cmd(8'h4A); dat(8'h77); cmd(8'h4A);
    rd_addr = 9'(2 * 64 + 10);
    dat(8'h88);
    chk("read_first", 32'(rd_data), 32'(8'h77));
    read_check(2 * 64 + 10);

    // Controller clear sequence then display on.
    cmd(8'hC0);
    for (int p = 0; p < 8; p++) begin
      cmd(8'hB8 | 8'(p));
      cmd(8'h40);
      for (int y = 0; y < 64; y++) dat(8'h00);
    end
    cmd(8'h3F);
    for (int a = 0; a < 512; a++) read_check(a);

    // Panel reset in the middle of a frame.
    cmd(8'hBC); cmd(8'h50); dat(8'h3C); dat(8'hC3);
    lcd_reset(5);
    read_check(4 * 64 + 16);
    read_check(4 * 64 + 17);
    dat(8'h9E);
    read_check(0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        lcd_reset(int'($urandom_range(1, 4)));
      end else begin
        di = 1'($urandom);
        d  = 8'($urandom);
        cs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b10;
        if (cs == 2'b10 && $urandom_range(0, 7) == 0) cs = 2'b11;
        rw = ($urandom_range(0, 9) == 0);
        strobe(di, d, cs, rw);
      end
    end
    for (int a = 0; a < 512; a++) read_check(a);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
